// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - master request/response and shared bus signals of bus_arbiter
// Optional lock inputs appear when BUS_ARB_LOCK_EN is defined.
interface bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_ack;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_ack;
    logic [DATA_W-1:0] m1_rdata;

    logic              bus_write;
    logic [ADDR_W-1:0] bus_address;
    logic [DATA_W-1:0] bus_writedata;
    logic [DATA_W-1:0] bus_readdata;

`ifdef BUS_ARB_LOCK_EN
    logic              m0_lock;
    logic              m1_lock;
`endif

    // arbiter side
    modport slave (
`ifdef BUS_ARB_LOCK_EN
        input  m0_lock, m1_lock,
`endif
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_ack, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_ack, m1_rdata,
        output bus_write, bus_address, bus_writedata,
        input  bus_readdata
    );

    // requesters and bus side
    modport master (
`ifdef BUS_ARB_LOCK_EN
        output m0_lock, m1_lock,
`endif
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_ack, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_ack, m1_rdata,
        input  bus_write, bus_address, bus_writedata,
        output bus_readdata
    );
endinterface

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master round-robin arbiter, one bus access per 3 cycles
// Optional lock feature enabled by defining BUS_ARB_LOCK_EN.
module bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    bus_arbiter_if.slave     bif,
    output logic             grant_id,
    output logic             busy,
    output logic [CNT_W-1:0] txn_cnt
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t state;
    logic   last_grant;
    logic   cmd_we;
    logic   rr_winner;
    logic   winner;

    always_comb begin
        rr_winner = bif.m1_req;
        if (bif.m0_req && bif.m1_req) begin
            rr_winner = ~last_grant;
        end
    end

`ifdef BUS_ARB_LOCK_EN
    logic       last_lock;
    logic       after_resp;
    logic [2:0] lock_cnt;
    logic       hold;
    logic       win_lock;

    // A locked owner keeps the bus only in the IDLE cycle right after its RESP,
    // and for at most four grants in a row.
    always_comb begin
        hold     = after_resp && last_lock && (lock_cnt < 3'd4) &&
                   (last_grant ? bif.m1_req : bif.m0_req);
        winner   = hold ? last_grant : rr_winner;
        win_lock = winner ? bif.m1_lock : bif.m0_lock;
    end
`else
    always_comb begin
        winner = rr_winner;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            last_grant        <= 1'b1;
            cmd_we            <= 1'b0;
            grant_id          <= 1'b0;
            busy              <= 1'b0;
            txn_cnt           <= '0;
            bif.m0_ack        <= 1'b0;
            bif.m1_ack        <= 1'b0;
            bif.m0_rdata      <= '0;
            bif.m1_rdata      <= '0;
            bif.bus_write     <= 1'b0;
            bif.bus_address   <= '0;
            bif.bus_writedata <= '0;
`ifdef BUS_ARB_LOCK_EN
            last_lock         <= 1'b0;
            after_resp        <= 1'b0;
            lock_cnt          <= '0;
`endif
        end else begin
`ifdef BUS_ARB_LOCK_EN
            after_resp <= (state == RESP);
`endif
            case (state)
                IDLE: begin
                    if (bif.m0_req || bif.m1_req) begin
                        state             <= ACCESS;
                        busy              <= 1'b1;
                        grant_id          <= winner;
                        last_grant        <= winner;
                        cmd_we            <= winner ? bif.m1_we : bif.m0_we;
                        bif.bus_write     <= winner ? bif.m1_we : bif.m0_we;
                        bif.bus_address   <= winner ? bif.m1_addr : bif.m0_addr;
                        bif.bus_writedata <= winner ? bif.m1_wdata : bif.m0_wdata;
`ifdef BUS_ARB_LOCK_EN
                        last_lock <= win_lock;
                        if (!win_lock) begin
                            lock_cnt <= '0;
                        end else if (winner == last_grant && last_lock) begin
                            lock_cnt <= (lock_cnt == 3'd4) ? lock_cnt : lock_cnt + 3'd1;
                        end else begin
                            lock_cnt <= 3'd1;
                        end
`endif
                    end
                end
                ACCESS: begin
                    state         <= RESP;
                    bif.bus_write <= 1'b0;
                    if (grant_id) begin
                        bif.m1_rdata <= cmd_we ? '0 : bif.bus_readdata;
                        bif.m1_ack   <= 1'b1;
                    end else begin
                        bif.m0_rdata <= cmd_we ? '0 : bif.bus_readdata;
                        bif.m0_ack   <= 1'b1;
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    bif.m0_ack <= 1'b0;
                    bif.m1_ack <= 1'b0;
                    txn_cnt    <= txn_cnt + 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - scoreboard bench for bus_arbiter with a small bus memory model
module tb_bus_arbiter;
    logic        clk;
    logic        rst_n;
    logic        grant_id;
    logic        busy;
    logic [15:0] txn_cnt;

    bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bif ();

    bus_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bif      (bif),
        .grant_id (grant_id),
        .busy     (busy),
        .txn_cnt  (txn_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [0:255];
    assign bif.bus_readdata = mem[bif.bus_address[9:2]];
    always @(posedge clk) begin
        if (bif.bus_write) mem[bif.bus_address[9:2]] <= bif.bus_writedata;
    end

    typedef struct {
        logic        id;
        logic [31:0] rdata;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   exp_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Pops one expected response per acknowledged transaction.
    always @(negedge clk) begin
        if (rst_n && (bif.m0_ack || bif.m1_ack)) begin
            check("ack_exclusive", {bif.m0_ack, bif.m1_ack} != 2'b11, 1'b1);
            if (q.size() == 0) begin
                check("unexpected_ack", {bif.m0_ack, bif.m1_ack}, 2'b00);
            end else begin
                mon_e = q.pop_front();
                check("ack_id", bif.m1_ack, mon_e.id);
                check("ack_rdata", mon_e.id ? bif.m1_rdata : bif.m0_rdata, mon_e.rdata);
            end
        end
    end

    task automatic set_master(input logic id, input logic req, input logic we,
                              input logic [31:0] addr, input logic [31:0] wdata);
        if (id) begin
            bif.m1_req = req; bif.m1_we = we; bif.m1_addr = addr; bif.m1_wdata = wdata;
        end else begin
            bif.m0_req = req; bif.m0_we = we; bif.m0_addr = addr; bif.m0_wdata = wdata;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_cnt = 0;
    endtask

    task automatic single(input logic id, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rd);
        set_master(id, 1'b1, we, addr, wdata);
        q.push_back('{id, exp_rd});
        @(negedge clk);
        check("idle_bus_write", bif.bus_write, 1'b0);
        @(negedge clk);
        check("acc_bus_write", bif.bus_write, we);
        check("acc_addr", bif.bus_address, addr);
        if (we) check("acc_wdata", bif.bus_writedata, wdata);
        check("acc_grant", grant_id, id);
        check("acc_busy", busy, 1'b1);
        @(negedge clk);
        check("resp_bus_write", bif.bus_write, 1'b0);
        check("resp_ack", id ? bif.m1_ack : bif.m0_ack, 1'b1);
        @(posedge clk);
        #1 set_master(id, 1'b0, 1'b0, 32'h0, 32'h0);
        exp_cnt++;
        check("txn_cnt", txn_cnt, exp_cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before the bench completed");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        set_master(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_master(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
`ifdef BUS_ARB_LOCK_EN
        bif.m0_lock = 1'b0;
        bif.m1_lock = 1'b0;
`endif
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_bus_write", bif.bus_write, 1'b0);
        check("rst_bus_address", bif.bus_address, 32'h0);
        check("rst_bus_writedata", bif.bus_writedata, 32'h0);
        check("rst_m0_ack", bif.m0_ack, 1'b0);
        check("rst_m1_ack", bif.m1_ack, 1'b0);
        check("rst_m0_rdata", bif.m0_rdata, 32'h0);
        check("rst_m1_rdata", bif.m1_rdata, 32'h0);
        check("rst_grant_id", grant_id, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_txn_cnt", txn_cnt, 16'h0);
        do_reset();

        single(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0);
        single(1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF);

        // m0 withdraws its request during ACCESS
        set_master(1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
        q.push_back('{1'b0, 32'hDEAD_BEEF});
        @(posedge clk);
        #1 set_master(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("wd_busy", busy, 1'b1);
        @(negedge clk);
        check("wd_ack", bif.m0_ack, 1'b1);
        repeat (2) begin
            @(negedge clk);
            check("wd_idle_busy", busy, 1'b0);
            check("wd_idle_write", bif.bus_write, 1'b0);
        end
        exp_cnt++;
        check("wd_txn_cnt", txn_cnt, exp_cnt);

        // contention from reset: grants 0,1,0,1
        do_reset();
        set_master(1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
        set_master(1'b1, 1'b1, 1'b1, 32'h0000_0020, 32'h0000_A5A5);
        q.push_back('{1'b0, 32'hDEAD_BEEF});
        q.push_back('{1'b1, 32'h0});
        q.push_back('{1'b0, 32'hDEAD_BEEF});
        q.push_back('{1'b1, 32'h0});
        repeat (12) @(posedge clk);
        #1 set_master(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_master(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        check("cont_txn_cnt", txn_cnt, 16'd4);
        check("cont_mem_write", mem[8], 32'h0000_A5A5);

        // asynchronous reset while a write is in ACCESS
        set_master(1'b0, 1'b1, 1'b1, 32'h0000_0030, 32'h0000_0055);
        @(negedge clk);
        @(negedge clk);
        check("rst_acc_write_before", bif.bus_write, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_acc_bus_write", bif.bus_write, 1'b0);
        check("rst_acc_ack", bif.m0_ack, 1'b0);
        check("rst_acc_txn_cnt", txn_cnt, 16'h0);
        check("rst_acc_busy", busy, 1'b0);
        set_master(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_acc_no_ack", bif.m0_ack, 1'b0);
        check("rst_acc_mem", mem[12], 32'h0);
        @(posedge clk);
        #1 set_master(1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
        set_master(1'b1, 1'b1, 1'b0, 32'h0000_0020, 32'h0);
        q.push_back('{1'b0, 32'hDEAD_BEEF});
        @(negedge clk);
        @(negedge clk);
        check("post_rst_grant", grant_id, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 set_master(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_master(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        check("post_rst_txn_cnt", txn_cnt, 16'd1);

`ifdef BUS_ARB_LOCK_EN
        // locked m0 against m1: 0,0,0,0,1,0
        do_reset();
        bif.m0_lock = 1'b1;
        set_master(1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
        set_master(1'b1, 1'b1, 1'b0, 32'h0000_0020, 32'h0);
        for (int i = 0; i < 6; i++) begin
            if (i == 4) q.push_back('{1'b1, 32'h0000_A5A5});
            else q.push_back('{1'b0, 32'hDEAD_BEEF});
        end
        repeat (18) @(posedge clk);
        #1 set_master(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_master(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        bif.m0_lock = 1'b0;
        check("lock_txn_cnt", txn_cnt, 16'd6);
`endif

        repeat (4) @(negedge clk);
        check("scoreboard_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
